// File: rtl/lsu_ctrl.sv
// Load/store bus responder: stalls the core across a req/ack data-memory transaction.
// Optional bus watchdog enabled by defining LSU_TIMEOUT_EN (limit set by TIMEOUT).
module lsu_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_en,
  input  logic        store_en,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        exc,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  addr_q;
  logic [2:0]  funct3_q;
  logic        to_flag;
  logic        to_hit;
  logic        legal_ld, legal_st, aligned;
  logic        valid, bad;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [31:0] ld_shift, ld_ext;

  always_comb begin
    legal_ld = 1'b0;
    legal_st = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: begin legal_ld = 1'b1; legal_st = 1'b1; end
      3'b100, 3'b101:         legal_ld = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    aligned = 1'b1;
    case (funct3[1:0])
      2'b01:   aligned = ~addr[0];
      2'b10:   aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  // Both-enables-high fails the XOR and so lands in the exception path.
  assign valid = (state == IDLE) && (load_en ^ store_en) &&
                 (load_en ? legal_ld : legal_st) && aligned;
  assign bad   = (state == IDLE) && (load_en || store_en) && !valid;

  assign stall = !rst && (valid || state == REQ);
  assign exc   = !rst && (bad || (state == DONE && to_flag));

  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = wdata;
    if (store_en) begin
      case (funct3[1:0])
        2'b00: begin
          be_nxt    = 4'b0001 << addr[1:0];
          wdata_nxt = {4{wdata[7:0]}};
        end
        2'b01: begin
          be_nxt    = addr[1] ? 4'b1100 : 4'b0011;
          wdata_nxt = {2{wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ld_shift = mem_rdata >> {addr_q, 3'b000};
    case (funct3_q)
      3'b000:  ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_ext = {24'd0, ld_shift[7:0]};
      3'b101:  ld_ext = {16'd0, ld_shift[15:0]};
      default: ld_ext = ld_shift;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || valid) begin
      cnt <= '0;
    end else if (state == REQ && !mem_ack) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Fires on the REQ cycle whose missing ack would bring the count to TIMEOUT.
  assign to_hit = (state == REQ) && !mem_ack && (cnt == CW'(TIMEOUT - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid) state_nxt = REQ;
      REQ:     if (mem_ack || to_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
      addr_q    <= '0;
      funct3_q  <= '0;
      to_flag   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (valid) begin
        mem_req   <= 1'b1;
        mem_we    <= store_en;
        mem_addr  <= {addr[31:2], 2'b00};
        mem_be    <= be_nxt;
        mem_wdata <= wdata_nxt;
        addr_q    <= addr[1:0];
        funct3_q  <= funct3;
        to_flag   <= 1'b0;
      end
      if (state == REQ) begin
        if (mem_ack) begin
          mem_req <= 1'b0;
          if (!mem_we) rdata <= ld_ext;
        end else if (to_hit) begin
          mem_req <= 1'b0;
          to_flag <= 1'b1;
          if (!mem_we) rdata <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: expected bus fields and results are queued at accept
// and checked against the DUT while the transaction runs and in its DONE cycle.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_en, store_en;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        stall, exc;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rd;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        we;
    int unsigned stalls;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_rd = '0;

  lsu_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .store_en(store_en),
    .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
    .stall(stall), .exc(exc), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction; ack arrives on the (wait_cyc+1)-th REQ cycle.
  task automatic access(input string nm, input logic ld, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] md, input int unsigned wait_cyc,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input logic [31:0] exp_rd);
    exp_t e;
    exp_t f;
    int unsigned nst;
    int unsigned n;
    logic acked;
    load_en = ld; store_en = !ld; funct3 = f3; addr = a; wdata = wd; mem_ack = 1'b0;
    e.rd = ld ? exp_rd : last_rd;
    e.addr = {a[31:2], 2'b00};
    e.be = exp_be;
    e.wd = exp_wd;
    e.we = !ld;
    e.stalls = wait_cyc + 2;
    sb.push_back(e);
    if (ld) last_rd = exp_rd;
    @(negedge clk);
    checks++; if (stall !== 1'b1 || exc !== 1'b0 || mem_req !== 1'b0) begin errors++;
      $display("FAIL %s accept: stall=%0b exc=%0b req=%0b want 1/0/0", nm, stall, exc, mem_req); end
    nst = (stall === 1'b1) ? 1 : 0;
    next_cycle();
    load_en = 1'b0; store_en = 1'b0;
    acked = 1'b0;
    n = 0;
    while (!acked && n < 64) begin
      mem_ack = (n == wait_cyc);
      mem_rdata = md;
      @(negedge clk);
      if (stall === 1'b1) nst++;
      checks++; if (mem_req !== 1'b1 || mem_we !== sb[0].we || mem_addr !== sb[0].addr || mem_be !== sb[0].be) begin errors++;
        $display("FAIL %s req%0d: req=%0b we=%0b addr=%h be=%b want 1/%0b/%h/%b", nm, n, mem_req, mem_we, mem_addr, mem_be, sb[0].we, sb[0].addr, sb[0].be); end
      if (!ld) begin
        checks++; if (mem_wdata !== sb[0].wd) begin errors++;
          $display("FAIL %s wdata%0d: got %h want %h", nm, n, mem_wdata, sb[0].wd); end
      end
      acked = mem_ack;
      n++;
      next_cycle();
    end
    mem_ack = 1'b0;
    checks++; if (!acked) begin errors++; $display("FAIL %s ack_budget: no ack within 64 cycles", nm); end
    @(negedge clk);
    f = sb.pop_front();
    checks++; if (stall !== 1'b0 || mem_req !== 1'b0 || exc !== 1'b0) begin errors++;
      $display("FAIL %s done: stall=%0b req=%0b exc=%0b want 0/0/0", nm, stall, mem_req, exc); end
    checks++; if (rdata !== f.rd) begin errors++; $display("FAIL %s rdata: got %h want %h", nm, rdata, f.rd); end
    checks++; if (nst != f.stalls) begin errors++; $display("FAIL %s stall_cycles: got %0d want %0d", nm, nst, f.stalls); end
    next_cycle();
  endtask

  task automatic bad_req(input string nm, input logic ld, input logic st,
                         input logic [2:0] f3, input logic [31:0] a);
    load_en = ld; store_en = st; funct3 = f3; addr = a; wdata = 32'h5555_AAAA;
    @(negedge clk);
    checks++; if (exc !== 1'b1 || stall !== 1'b0 || mem_req !== 1'b0) begin errors++;
      $display("FAIL %s: exc=%0b stall=%0b req=%0b want 1/0/0", nm, exc, stall, mem_req); end
    next_cycle();
    load_en = 1'b0; store_en = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || exc !== 1'b0) begin errors++;
      $display("FAIL %s after: req=%0b exc=%0b want 0/0", nm, mem_req, exc); end
    next_cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1; load_en = 1'b0; store_en = 1'b0; funct3 = 3'b000;
    addr = '0; wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    next_cycle();
    next_cycle();
    load_en = 1'b1; funct3 = 3'b010; addr = 32'h100;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_be !== 4'b0000) begin errors++;
      $display("FAIL reset_ctl: req=%0b we=%0b be=%b want 0/0/0000", mem_req, mem_we, mem_be); end
    checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || rdata !== 32'h0) begin errors++;
      $display("FAIL reset_data: addr=%h wdata=%h rdata=%h want 0/0/0", mem_addr, mem_wdata, rdata); end
    checks++; if (stall !== 1'b0 || exc !== 1'b0) begin errors++;
      $display("FAIL reset_stall: stall=%0b exc=%0b want 0/0", stall, exc); end
    next_cycle();
    load_en = 1'b0;
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_reset_mid();
    load_en = 1'b1; funct3 = 3'b010; addr = 32'h300;
    @(negedge clk);
    next_cycle();
    load_en = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rstmid_req: got %0b want 1", mem_req); end
    rst = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rstmid_stall: got %0b want 0", stall); end
    next_cycle();
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || stall !== 1'b0 || exc !== 1'b0) begin errors++;
      $display("FAIL rstmid_idle: req=%0b stall=%0b exc=%0b want 0/0/0", mem_req, stall, exc); end
    next_cycle();
    mem_ack = 1'b0;
    @(negedge clk);
    checks++; if (rdata !== 32'h0 || mem_req !== 1'b0) begin errors++;
      $display("FAIL rstmid_late_ack: rdata=%h req=%0b want 0/0", rdata, mem_req); end
    last_rd = '0;
    next_cycle();
  endtask

  task automatic test_loads();
    access("lw",      1'b1, 3'b010, 32'h100, '0, 32'hDEAD_BEEF, 0, 4'b1111, '0, 32'hDEAD_BEEF);
    access("lb_103",  1'b1, 3'b000, 32'h103, '0, 32'h80FF_0011, 0, 4'b1111, '0, 32'hFFFF_FF80);
    access("lbu_103", 1'b1, 3'b100, 32'h103, '0, 32'h80FF_0011, 1, 4'b1111, '0, 32'h0000_0080);
    access("lh_102",  1'b1, 3'b001, 32'h102, '0, 32'h80FF_0011, 0, 4'b1111, '0, 32'hFFFF_80FF);
    access("lhu_102", 1'b1, 3'b101, 32'h102, '0, 32'h80FF_0011, 2, 4'b1111, '0, 32'h0000_80FF);
    access("lb_100",  1'b1, 3'b000, 32'h100, '0, 32'h80FF_0011, 0, 4'b1111, '0, 32'h0000_0011);
  endtask

  task automatic test_stores();
    access("sh_102", 1'b0, 3'b001, 32'h102, 32'h1234_ABCD, '0, 3, 4'b1100, 32'hABCD_ABCD, '0);
    access("sb_201", 1'b0, 3'b000, 32'h201, 32'h0000_00A5, '0, 0, 4'b0010, 32'hA5A5_A5A5, '0);
    access("sh_100", 1'b0, 3'b001, 32'h100, 32'h0000_BEEF, '0, 1, 4'b0011, 32'hBEEF_BEEF, '0);
    access("sw_204", 1'b0, 3'b010, 32'h204, 32'hCAFE_F00D, '0, 0, 4'b1111, 32'hCAFE_F00D, '0);
  endtask

  task automatic test_exc();
    bad_req("exc_lw_mis",  1'b1, 1'b0, 3'b010, 32'h101);
    bad_req("exc_lh_mis",  1'b1, 1'b0, 3'b001, 32'h103);
    bad_req("exc_ld_f011", 1'b1, 1'b0, 3'b011, 32'h100);
    bad_req("exc_st_f100", 1'b0, 1'b1, 3'b100, 32'h100);
    bad_req("exc_sw_mis",  1'b0, 1'b1, 3'b010, 32'h102);
    bad_req("exc_both",    1'b1, 1'b1, 3'b010, 32'h100);
  endtask

  task automatic test_back_to_back();
    access("b2b_lw", 1'b1, 3'b010, 32'h500, '0, 32'h0123_4567, 0, 4'b1111, '0, 32'h0123_4567);
    access("b2b_sw", 1'b0, 3'b010, 32'h504, 32'h89AB_CDEF, '0, 0, 4'b1111, 32'h89AB_CDEF, '0);
    access("b2b_lbu", 1'b1, 3'b100, 32'h502, '0, 32'h0123_4567, 0, 4'b1111, '0, 32'h0000_0023);
    // Ack coinciding with the watchdog limit must still complete normally.
    access("ack_at_limit", 1'b1, 3'b010, 32'h600, '0, 32'h7777_1234, 3, 4'b1111, '0, 32'h7777_1234);
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    load_en = 1'b1; store_en = 1'b0; funct3 = 3'b010; addr = 32'h400; mem_ack = 1'b0;
    @(negedge clk);
    next_cycle();
    load_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (mem_req !== 1'b1 || stall !== 1'b1) begin errors++;
        $display("FAIL to_req%0d: req=%0b stall=%0b want 1/1", i, mem_req, stall); end
      next_cycle();
    end
    @(negedge clk);
    checks++; if (exc !== 1'b1 || stall !== 1'b0 || mem_req !== 1'b0 || rdata !== 32'h0) begin errors++;
      $display("FAIL to_done: exc=%0b stall=%0b req=%0b rdata=%h want 1/0/0/0", exc, stall, mem_req, rdata); end
    next_cycle();
    @(negedge clk);
    checks++; if (exc !== 1'b0) begin errors++; $display("FAIL to_exc_pulse: got %0b want 0", exc); end
    last_rd = '0;
    next_cycle();
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid();
    test_loads();
    test_stores();
    test_exc();
    test_back_to_back();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
